// File: rtl/viterbi_frame_ctrl_if.sv
// Channel, decoder-side and output signals of viterbi_frame_ctrl.
// slave = controller view, master = channel/decoder/sink view.
interface viterbi_frame_ctrl_if;
    logic in_bit;
    logic in_valid;
    logic dec_rst_n;
    logic dec_x;
    logic dec_phase;
    logic dec_y;
    logic out_bit;
    logic out_valid;
    logic frame_done;
    logic abort;
    logic busy;

    modport slave (
        input  in_bit, in_valid, dec_y,
        output dec_rst_n, dec_x, dec_phase, out_bit, out_valid, frame_done, abort, busy
    );

    modport master (
        output in_bit, in_valid, dec_y,
        input  dec_rst_n, dec_x, dec_phase, out_bit, out_valid, frame_done, abort, busy
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the viterbi decoder: sync hunt, coded-bit forwarding, trellis flush, capture.
// Define VFC_SYNC_TOL_EN to accept sync words with at most one bit error.
module viterbi_frame_ctrl #(
    parameter int unsigned         SYNC_LEN   = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD  = 8'b1011_0001,
    parameter int unsigned         FRAME_BITS = 64,
    parameter int unsigned         TAIL_BITS  = 2,
    parameter int unsigned         DEC_LAT    = 16
) (
    input logic                 clk,
    input logic                 reset,
    viterbi_frame_ctrl_if.slave bus
);
    localparam int unsigned P_W = $clog2(FRAME_BITS + DEC_LAT + 1);
    localparam int unsigned K_W = $clog2(FRAME_BITS + 1);
    localparam logic [P_W-1:0] LAST_CH_PAIR = P_W'(FRAME_BITS + TAIL_BITS - 1);
    localparam logic [P_W-1:0] LAT          = P_W'(DEC_LAT);
    localparam logic [K_W-1:0] LAST_K       = K_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {HUNT, LOAD, DRAIN} state_e;

    state_e              state_q, state_d;
    logic [SYNC_LEN-2:0] hist_q, hist_d;    // the current in_bit completes the window
    logic [P_W-1:0]      p_q, p_d;
    logic [K_W-1:0]      k_q, k_d;
    logic                ph_q, ph_d;        // phase of the next bit to forward
    logic                dec_rst_n_q, dec_rst_n_d;
    logic                dec_x_q, dec_x_d;
    logic                dec_phase_q, dec_phase_d;
    logic                out_bit_q, out_bit_d;
    logic                out_valid_q, out_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                abort_q, abort_d;
    logic                busy_q, busy_d;

    logic [SYNC_LEN-1:0] window;
    logic                sync_hit;

    assign window = {hist_q, bus.in_bit};

`ifdef VFC_SYNC_TOL_EN
    logic [SYNC_LEN-1:0] diff;
    assign diff     = window ^ SYNC_WORD;
    // Clearing the lowest set bit leaves zero only for distance 0 or 1.
    assign sync_hit = (diff & (diff - SYNC_LEN'(1))) == '0;
`else
    assign sync_hit = (window == SYNC_WORD);
`endif

    always_comb begin
        // NOTE: every _d gets a default first, so no path through the case infers a latch.
        state_d      = state_q;
        hist_d       = hist_q;
        p_d          = p_q;
        k_d          = k_q;
        ph_d         = ph_q;
        dec_x_d      = 1'b0;
        dec_phase_d  = 1'b0;
        out_bit_d    = 1'b0;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        abort_d      = 1'b0;

        case (state_q)
            HUNT: begin
                if (bus.in_valid) begin
                    hist_d = window[SYNC_LEN-2:0];
                    if (sync_hit) begin
                        state_d = LOAD;
                        hist_d  = '0;
                        p_d     = '0;
                        k_d     = '0;
                        ph_d    = 1'b0;
                    end
                end
            end
            LOAD, DRAIN: begin
                if (state_q == LOAD && !bus.in_valid) begin
                    // A gap in the channel drops the frame; this wins over any capture.
                    state_d = HUNT;
                    hist_d  = '0;
                    abort_d = 1'b1;
                end else begin
                    dec_x_d     = (state_q == LOAD) ? bus.in_bit : 1'b0;
                    dec_phase_d = ph_q;
                    ph_d        = ~ph_q;
                    if (state_q == LOAD && ph_q && p_q == LAST_CH_PAIR) begin
                        state_d = DRAIN;
                    end
                    // p_q is the pair now on dec_x; it advances once its second bit has been shown.
                    if (dec_phase_q) begin
                        p_d = p_q + P_W'(1);
                        if (p_q >= LAT) begin
                            out_bit_d   = bus.dec_y;
                            out_valid_d = 1'b1;
                            k_d         = k_q + K_W'(1);
                            if (k_q == LAST_K) begin
                                frame_done_d = 1'b1;
                                state_d      = HUNT;
                                dec_x_d      = 1'b0;
                                dec_phase_d  = 1'b0;
                            end
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        dec_rst_n_d = (state_d != HUNT);
        busy_d      = (state_d != HUNT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= HUNT;
            hist_q       <= '0;
            p_q          <= '0;
            k_q          <= '0;
            ph_q         <= 1'b0;
            dec_rst_n_q  <= 1'b0;
            dec_x_q      <= 1'b0;
            dec_phase_q  <= 1'b0;
            out_bit_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            p_q          <= p_d;
            k_q          <= k_d;
            ph_q         <= ph_d;
            dec_rst_n_q  <= dec_rst_n_d;
            dec_x_q      <= dec_x_d;
            dec_phase_q  <= dec_phase_d;
            out_bit_q    <= out_bit_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            abort_q      <= abort_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.dec_rst_n  = dec_rst_n_q;
    assign bus.dec_x      = dec_x_q;
    assign bus.dec_phase  = dec_phase_q;
    assign bus.out_bit    = out_bit_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.abort      = abort_q;
    assign bus.busy       = busy_q;
endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame-level sequencer for the `viterbi` decoder.
- Hunts a sync word in the serial coded channel stream.
- Holds the decoder in reset between frames and forwards the frame's coded bits with a pair-phase strobe that replaces the free-running `clk_div2`.
- Flushes the trellis with zero pairs and captures exactly `FRAME_BITS` decoded bits, discarding tail bits and the decoder's startup latency.

## Interface
- `SYNC_LEN`, 8: sync word length in channel bits.
- `SYNC_WORD`, 8'b1011_0001: sync pattern; MSB is received first.
- `FRAME_BITS`, 64: information bits per frame.
- `TAIL_BITS`, 2: encoder tail bits (K−1). Sent as 2·TAIL_BITS coded bits after the data.
- `DEC_LAT`, 16: decoder latency in pairs. Must satisfy `DEC_LAT ≥ TAIL_BITS`.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_bit`  in  1  coded channel bit.
- `in_valid`  in  1  `in_bit` qualifier.
- `dec_rst_n`  out  1  drives the decoder `reset`.
- `dec_x`  out  1  coded bit to the decoder `x`.
- `dec_phase`  out  1  pair phase to the decoder `clk_div2`: 0 = first bit of pair, 1 = second.
- `dec_y`  in  1  decoded bit from the decoder `y`.
- `out_bit`  out  1  decoded information bit.
- `out_valid`  out  1  `out_bit` qualifier.
- `frame_done`  out  1  one-cycle pulse, coincident with the last `out_valid`.
- `abort`  out  1  one-cycle pulse when a frame is dropped.
- `busy`  out  1  high in LOAD and DRAIN.

## Operation
- **States:** HUNT, LOAD, DRAIN.
- **Reset values:** all outputs 0; state HUNT; counters 0.
- **HUNT**
  - `dec_rst_n`=0.
  - Each `in_valid` cycle shifts `in_bit` into a SYNC_LEN shift register.
  - Match: shift register including the current `in_bit` equals `SYNC_WORD` → LOAD on the next edge.
  - `in_valid`=0 leaves the register unchanged.
- **LOAD**
  - `dec_rst_n`=1.
  - Each cycle forwards `in_bit` to `dec_x` and toggles `dec_phase`. The first forwarded bit has phase 0.
  - Pair counter p increments after each phase-1 bit.
  - `in_valid` must stay high for all 2·(FRAME_BITS+TAIL_BITS) coded bits.
  - `in_valid`=0 in LOAD: `abort` pulses, state returns to HUNT, `dec_rst_n`=0 next cycle, shift register cleared, capture stops.
  - After the last channel pair → DRAIN.
- **DRAIN**
  - Forwards `dec_x`=0 pairs (flush), `dec_phase` continues toggling, `in_bit`/`in_valid` ignored.
  - Flush length is DEC_LAT−TAIL_BITS pairs (14 with defaults).
  - Channel bits arriving during DRAIN are not searched for sync.
- **Capture (LOAD and DRAIN)**
  - On each cycle where `dec_phase`=1 is presented and p ≥ DEC_LAT, sample `dec_y` as decoded bit k = p−DEC_LAT.
  - Registered to `out_bit`/`out_valid` one cycle later.
  - k counts 0..FRAME_BITS−1. Tail-bit decodes are never captured.
- **End of frame:** after capturing k=FRAME_BITS−1, `frame_done` pulses with that `out_valid` and the state returns to HUNT. `dec_rst_n`=0 from the following cycle.
- **Widths:** p is ⌈log2(FRAME_BITS+DEC_LAT+1)⌉ bits, k is ⌈log2(FRAME_BITS+1)⌉ bits; no wrap within a frame.

## Timing
- `dec_x`/`dec_phase` are registered: `in_bit` at edge t appears at t+1.
- Sync match at edge t → `dec_rst_n`=1 and the first coded bit on `dec_x` at t+1.
  - That first bit is the `in_bit` sampled at edge t+1, so it appears at t+2.
  - `dec_rst_n` rises one cycle before the first data bit; `dec_x`=0 and `dec_phase`=0 during that cycle.
- **Decoder contract:** decoded bit k is valid on `dec_y` in the cycle the phase-1 bit of pair k+DEC_LAT is on `dec_x`.
- Per frame, `busy` is high for 1 + 2·(FRAME_BITS+DEC_LAT) cycles (161 with defaults).
- **Simultaneous events**
  - Abort takes priority over capture in the same cycle.
  - `reset` low overrides everything; mid-frame it returns to HUNT with all outputs 0 on the next edge.
- **Back-to-back frames:** the earliest next sync match is the cycle after `frame_done`.

## Configuration
- `VFC_SYNC_TOL_EN` defined: HUNT accepts a Hamming distance ≤1 between the shift register and `SYNC_WORD`.
- Undefined: exact match only. Distance logic is not synthesized.

## Test plan
- **Reset:** hold `reset`=0 3 cycles while driving `in_valid`=1 → `dec_rst_n`, `out_valid`, `busy`, `abort`, `frame_done` all 0; no lock on a sync word sent during reset.
- **Nominal frame:** sync 10110001 + 132 coded bits of a known 64-bit message; bench models the decoder with DEC_LAT=16 → exactly 64 `out_valid` matching the message, `frame_done` on the 64th, `busy` high 161 cycles.
- **Abort:** drop `in_valid` at coded bit 37 → `abort` pulses once, next cycle `dec_rst_n`=0, no further `out_valid`, no `frame_done`; a following clean frame decodes correctly.
- **Tolerance:** sync 10110011 (1 bit error) → no lock without `VFC_SYNC_TOL_EN`; lock with it. 10110111 (2 errors) → no lock in either build.
- **Reset mid-DRAIN:** assert `reset` 5 cycles into flush → all outputs 0 next edge, `out_valid` count frozen, HUNT.
- **Back-to-back frames:** second sync starts the cycle after `frame_done` → second frame's 64 bits correct; channel bits sent during DRAIN cause no lock.
